// File: rtl/rr_grant_encoder8.sv
// rr_grant_encoder8: 8-way round-robin arbiter producing a registered 3-bit
// owner index plus valid qualifier for a downstream 3-to-8 decoder. A hold
// watchdog revokes any grant that outlives MAX_HOLD cycles.
module rr_grant_encoder8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Watchdog fires when the counter reaches MAX_HOLD-1 on an edge, which
    // yields exactly MAX_HOLD cycles of grant_valid.
    localparam logic       WDOG_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] idx_q, idx_nxt;
    logic [2:0] last_q, last_nxt;
    logic       valid_q, valid_nxt;
    logic       to_q, to_nxt;
    logic [7:0] hold_q, hold_nxt;

    logic       owner_done;
    logic       expire;

    // First requester found searching upward from last+1, wrapping 7->0.
    // The last candidate examined (offset 8) is the previous owner itself.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [2:0] cand;
        logic       found;
        rr_pick = 3'd0;
        found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign owner_done = rel | ~req[idx_q];
    assign expire     = WDOG_EN && (hold_q == HOLD_LAST);

    // State and all output-feeding registers; async reset aims the first search at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx_q   <= 3'd0;
            last_q  <= 3'd7;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state   <= state_nxt;
            idx_q   <= idx_nxt;
            last_q  <= last_nxt;
            valid_q <= valid_nxt;
            to_q    <= to_nxt;
            hold_q  <= hold_nxt;
        end
    end

    // Next-state logic: grant from IDLE, release on rel/drop, forced release on expiry.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        last_nxt  = last_q;
        valid_nxt = valid_q;
        to_nxt    = 1'b0;
        hold_nxt  = hold_q;
        case (state)
            IDLE: begin
                if (req != 8'd0) begin
                    idx_nxt   = rr_pick(req, last_q);
                    valid_nxt = 1'b1;
                    hold_nxt  = 8'd0;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                hold_nxt = sat_inc(hold_q);
                if (owner_done || expire) begin
                    valid_nxt = 1'b0;
                    last_nxt  = idx_q;
                    state_nxt = IDLE;
                    // A release by the owner wins over a simultaneous expiry.
                    to_nxt    = ~owner_done;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    always_comb begin
        grant_idx   = idx_q;
        grant_valid = valid_q;
        timeout     = to_q;
    end

endmodule

// File: tb/tb_rr_grant_encoder8.sv
// Testbench for rr_grant_encoder8: two instances (MAX_HOLD=4 and MAX_HOLD=0)
// share the same stimulus and are compared every cycle against a
// behavioural reference model, with directed scenarios followed by random traffic.
module tb_rr_grant_encoder8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic [2:0] gidx4, gidx0;
    logic       gval4, gval0;
    logic       tout4, tout0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 -> MAX_HOLD=4 instance, 1 -> MAX_HOLD=0 instance.
    int m_hold[2] = '{4, 0};
    bit m_valid[2];
    int m_idx[2];
    int m_last[2];
    int m_cycles[2];
    bit m_to[2];

    rr_grant_encoder8 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .grant_idx(gidx4), .grant_valid(gval4), .timeout(tout4)
    );

    rr_grant_encoder8 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .grant_idx(gidx0), .grant_valid(gval0), .timeout(tout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k]  = 1'b0;
            m_idx[k]    = 0;
            m_last[k]   = 7;
            m_cycles[k] = 0;
            m_to[k]     = 1'b0;
        end
    endtask

    // One rising edge of the abstract arbiter using the rules directly.
    task automatic model_step(input int k, input logic [7:0] r, input logic rl);
        if (m_valid[k]) begin
            m_cycles[k]++;
            if (rl || !r[m_idx[k]]) begin
                m_valid[k] = 1'b0;
                m_last[k]  = m_idx[k];
                m_to[k]    = 1'b0;
            end else if (m_hold[k] != 0 && m_cycles[k] == m_hold[k]) begin
                m_valid[k] = 1'b0;
                m_last[k]  = m_idx[k];
                m_to[k]    = 1'b1;
            end else begin
                m_to[k] = 1'b0;
            end
        end else begin
            m_to[k] = 1'b0;
            if (r != 8'd0) begin
                for (int d = 1; d <= 8; d++) begin
                    if (r[(m_last[k] + d) % 8]) begin
                        m_idx[k] = (m_last[k] + d) % 8;
                        break;
                    end
                end
                m_valid[k]  = 1'b1;
                m_cycles[k] = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("h4_valid", 32'(gval4), 32'(m_valid[0]));
        chk("h4_idx",   32'(gidx4), 32'(m_idx[0]));
        chk("h4_tout",  32'(tout4), 32'(m_to[0]));
        chk("h0_valid", 32'(gval0), 32'(m_valid[1]));
        chk("h0_idx",   32'(gidx0), 32'(m_idx[1]));
        chk("h0_tout",  32'(tout0), 32'(m_to[1]));
    endtask

    // Drive at the falling edge, clock once, sample at the next falling edge.
    task automatic cyc(input logic [7:0] r, input logic rl);
        req = r;
        rel = rl;
        @(posedge clk);
        model_step(0, r, rl);
        model_step(1, r, rl);
        @(negedge clk);
        check_model();
    endtask

    // Asynchronous reset asserted mid-cycle, outputs checked before any edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid4", 32'(gval4), 32'd0);
        chk("rst_idx4",   32'(gidx4), 32'd0);
        chk("rst_tout4",  32'(tout4), 32'd0);
        chk("rst_valid0", 32'(gval0), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        req   = 8'd0;
        rel   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("por_valid", 32'(gval4), 32'd0);
        chk("por_idx",   32'(gidx4), 32'd0);
        chk("por_tout",  32'(tout4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Grant index 5, then reset while it is held.
        cyc(8'h20, 1'b0);
        chk("own5_idx", 32'(gidx4), 32'd5);
        chk("own5_valid", 32'(gval4), 32'd1);
        do_reset();

        // Single requester 3, then drop it.
        cyc(8'h08, 1'b0);
        chk("single_idx", 32'(gidx4), 32'd3);
        chk("single_valid", 32'(gval4), 32'd1);
        cyc(8'h00, 1'b0);
        chk("single_drop", 32'(gval4), 32'd0);

        // Rotation with all requesters active, rel every third cycle.
        do_reset();
        for (int g = 0; g < 9; g++) begin
            cyc(8'hFF, 1'b0);
            chk("rot_idx", 32'(gidx4), 32'(g % 8));
            chk("rot_valid", 32'(gval4), 32'd1);
            cyc(8'hFF, 1'b0);
            cyc(8'hFF, 1'b1);
            chk("rot_gap", 32'(gval4), 32'd0);
        end

        // Wrap-around search.
        do_reset();
        cyc(8'h40, 1'b0);
        cyc(8'h00, 1'b0);
        cyc(8'h03, 1'b0);
        chk("wrap_idx0", 32'(gidx4), 32'd0);
        cyc(8'h00, 1'b0);
        cyc(8'h41, 1'b0);
        chk("wrap_idx6", 32'(gidx4), 32'd6);
        cyc(8'h00, 1'b0);

        // Watchdog on the MAX_HOLD=4 instance; MAX_HOLD=0 keeps the grant.
        cyc(8'h04, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cyc(8'h04, 1'b0);
            chk("wd_hold", 32'(gval4), 32'd1);
        end
        cyc(8'h04, 1'b0);
        chk("wd_revoke", 32'(gval4), 32'd0);
        chk("wd_tout", 32'(tout4), 32'd1);
        chk("nowd_keep", 32'(gval0), 32'd1);
        cyc(8'h04, 1'b0);
        chk("wd_regrant", 32'(gidx4), 32'd2);
        chk("wd_regrant_v", 32'(gval4), 32'd1);
        chk("wd_tout_clr", 32'(tout4), 32'd0);

        // rel on the expiry edge is a normal release.
        for (int c = 0; c < 3; c++) cyc(8'h04, 1'b0);
        cyc(8'h04, 1'b1);
        chk("coll_valid", 32'(gval4), 32'd0);
        chk("coll_tout", 32'(tout4), 32'd0);

        // rel in IDLE with no requests changes nothing.
        cyc(8'h00, 1'b1);
        chk("idle_rel_v", 32'(gval4), 32'd0);
        chk("idle_rel_idx", 32'(gidx4), 32'd2);

        // Random traffic.
        r = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            case ($urandom_range(0, 5))
                0: r = 8'd0;
                1: r = 8'(1 << $urandom_range(0, 7));
                2, 3: r = r;
                default: r = 8'($urandom);
            endcase
            cyc(r, ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
